mt_regfile: RTL and testbench
=============================

// Module: mt_regfile
// PURPOSE
//  Multi-thread register file for the GPU core: NUM_THREADS independent contexts of 2^REG_ADDR_WIDTH regs each.
//  Two read ports with registered (1-cycle) outputs and same-cycle write bypass; one write port.
//  Storage has no reset and is cleared by a sweep FSM (BRAM-friendly): full sweep after reset, per-thread sweep on request.
//  Sits between decode (read addresses) and writeback (write port) in each shader pipeline.
// PARAMETERS
//  DATA_WIDTH      64  data bits per register (default `DATA_WIDTH)
//  REG_ADDR_WIDTH  4   register address bits per thread (default `REG_ADDR_WIDTH)
//  NUM_THREADS     4   thread contexts, power of two >= 2; TID_W = $clog2(NUM_THREADS)
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               async active-low reset
//  ready      out  1               1 = idle, accepting reads/writes/clear requests
//  wena       in   1               write enable
//  wtid       in   TID_W           write thread id
//  waddr      in   REG_ADDR_WIDTH  write register address
//  wdata      in   DATA_WIDTH      write data
//  rd_en      in   1               read request
//  rd_tid     in   TID_W           read thread id (both ports)
//  rs1addr    in   REG_ADDR_WIDTH  port 1 address
//  rs2addr    in   REG_ADDR_WIDTH  port 2 address
//  rs1data    out  DATA_WIDTH      port 1 data, registered
//  rs2data    out  DATA_WIDTH      port 2 data, registered
//  rd_valid   out  1               rs1data/rs2data valid for read accepted previous cycle
//  clr_req    in   1               request clear of one thread context
//  clr_tid    in   TID_W           thread to clear
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-low on rst_n. Array index = {tid, addr}; NUMREGS = 2^REG_ADDR_WIDTH.
//  - Reset values: ready=0, rd_valid=0, rs1data=0, rs2data=0, FSM=S_SWEEP, sweep counter=0.
//  - FSM S_SWEEP: writes 0 to entry cnt each cycle, cnt 0..NUM_THREADS*NUMREGS-1, then -> S_READY.
//    ready rises the cycle after the last entry is written (NUM_THREADS*NUMREGS cycles after rst_n release).
//  - S_READY: ready=1. clr_req=1 -> S_TCLR, cnt=0, latched tid=clr_tid.
//  - S_TCLR: writes 0 to {tid,cnt}, cnt 0..NUMREGS-1, then -> S_READY. ready=0 throughout.
//  - rst_n assert at any time (incl. mid-sweep): immediate reset values; sweep restarts from 0 on release.
//  - Accept rules: wena, rd_en, clr_req take effect only while ready=1; ignored otherwise (no queuing).
//  - Cycle with ready=1 and clr_req: same-cycle read and write are still accepted; clear starts next cycle.
//  - Write: regs[{wtid,waddr}] <= wdata at clock edge.
//  - Read: accepted at edge N -> rs1data/rs2data/rd_valid=1 at N+1. rd_valid=0 in cycles with no accepted read;
//    rs1data/rs2data hold last value when no read.
//  - Bypass: accepted write with wtid==rd_tid and waddr==rsXaddr in same cycle -> rsXdata = wdata (write-first).
//    Different tid never bypasses. Both ports may bypass the same write.
//  - Read of a thread being cleared cannot occur (ready=0).
// CONFIGURATION
//  REGFILE_ZERO_REG_EN defined: register 0 of every thread always reads 0; writes to addr 0 discarded,
//   no bypass for addr 0. Not defined: register 0 is an ordinary register.
// STRUCTURE
//  defines.v: DATA_WIDTH, REG_ADDR_WIDTH, new NUM_THREADS and TID_WIDTH defines; FSM state encodings
//   (S_SWEEP, S_READY, S_TCLR) as localparams in this file.
//  Sub-module rf_clear_ctrl: FSM + sweep counter; outputs ready, clr_we, clr_addr. Top muxes clr_we/clr_addr
//   over the write port; array + read registers + bypass live in mt_regfile.
// TESTING
//  1 Reset: release rst_n, defaults (4 thr, 16 regs) -> ready=0 for 64 cycles, ready=1 on cycle 65;
//    read all 64 entries -> all 0, rd_valid=1 one cycle after each rd_en.
//  2 Write/read: write t1 r5=0xDEAD_BEEF; next cycle read t1 rs1=5 rs2=5 -> both 0xDEADBEEF next cycle;
//    read t2 r5 -> 0.
//  3 Bypass: same cycle wena t3 r7=0x1234 and rd_en t3 rs1=7 rs2=6 -> rs1data=0x1234, rs2data=old r6;
//    repeat with rd_tid=2 -> no bypass.
//  4 Thread clear: fill all threads with 0xA5; clr_req tid=2 -> ready=0 for 16 cycles; t2 regs read 0,
//    t0/t1/t3 read 0xA5; wena/rd_en during clear ignored (rd_valid stays 0, no data change).
//  5 Reset mid-sweep: assert rst_n low at sweep cycle 20 -> outputs to reset values immediately;
//    after release ready returns after a full 64 cycles.
//  6 REGFILE_ZERO_REG_EN: write t0 r0=0xFF, read t0 r0 (same cycle and later) -> 0; without macro -> 0xFF.

Source files
------------

// File: rtl/mt_regfile_pkg.sv
// Shared defaults and sweep/clear FSM state type for the multi-thread register file.
package mt_regfile_pkg;

  localparam int DEF_DATA_WIDTH     = 64;
  localparam int DEF_REG_ADDR_WIDTH = 4;
  localparam int DEF_NUM_THREADS    = 4;

  typedef enum logic [1:0] {
    S_SWEEP = 2'd0,
    S_READY = 2'd1,
    S_TCLR  = 2'd2
  } rf_state_e;

endpackage

// File: rtl/mt_regfile_clear_ctrl.sv
// rf_clear_ctrl: sweep/clear FSM that zeroes the whole array after reset and
// one thread context on request; drives ready and the clear write port.
module rf_clear_ctrl
  import mt_regfile_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int NUM_THREADS    = DEF_NUM_THREADS,
  parameter int TID_W          = $clog2(NUM_THREADS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr_req_i,
  input  logic [TID_W-1:0]                clr_tid_i,
  output logic                            ready_o,
  output logic                            clr_we_o,
  output logic [TID_W+REG_ADDR_WIDTH-1:0] clr_addr_o
);

  localparam int IDX_W = TID_W + REG_ADDR_WIDTH;

  rf_state_e         state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [TID_W-1:0]  tid_q, tid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SWEEP;
      cnt_q   <= '0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tid_q   <= tid_d;
    end
  end

  // The full sweep walks the flat index; a thread clear only walks the low address bits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tid_d      = tid_q;
    ready_o    = 1'b0;
    clr_we_o   = 1'b0;
    clr_addr_o = cnt_q;
    case (state_q)
      S_SWEEP: begin
        clr_we_o = 1'b1;
        if (cnt_q == {IDX_W{1'b1}}) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READY: begin
        ready_o = 1'b1;
        if (clr_req_i) begin
          state_d = S_TCLR;
          cnt_d   = '0;
          tid_d   = clr_tid_i;
        end
      end
      S_TCLR: begin
        clr_we_o   = 1'b1;
        clr_addr_o = {tid_q, cnt_q[REG_ADDR_WIDTH-1:0]};
        if (cnt_q[REG_ADDR_WIDTH-1:0] == {REG_ADDR_WIDTH{1'b1}}) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mt_regfile.sv
// mt_regfile: multi-thread register file, 2 registered read ports with write bypass, 1 write port.
// Optional macro REGFILE_ZERO_REG_EN makes register 0 of every thread hard-wired to zero.
module mt_regfile
  import mt_regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int NUM_THREADS    = DEF_NUM_THREADS,
  parameter int TID_W          = $clog2(NUM_THREADS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      ready,
  input  logic                      wena,
  input  logic [TID_W-1:0]          wtid,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      rd_en,
  input  logic [TID_W-1:0]          rd_tid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2addr,
  output logic [DATA_WIDTH-1:0]     rs1data,
  output logic [DATA_WIDTH-1:0]     rs2data,
  output logic                      rd_valid,
  input  logic                      clr_req,
  input  logic [TID_W-1:0]          clr_tid
);

  localparam int IDX_W   = TID_W + REG_ADDR_WIDTH;
  localparam int ENTRIES = NUM_THREADS * (2 ** REG_ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] regs_q [ENTRIES];
  logic                  clr_we;
  logic [IDX_W-1:0]      clr_addr;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rs1data_q, rs1data_d, rs2data_q, rs2data_d;
  logic                  rd_valid_q;

  rf_clear_ctrl #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .NUM_THREADS   (NUM_THREADS),
    .TID_W         (TID_W)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req_i (clr_req),
    .clr_tid_i (clr_tid),
    .ready_o   (ready),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

`ifdef REGFILE_ZERO_REG_EN
  assign wr_acc = ready && wena && (waddr != '0);
`else
  assign wr_acc = ready && wena;
`endif
  assign rd_acc = ready && rd_en;

  // Write-first bypass: a same-thread, same-address write in this cycle wins over the array.
  always_comb begin
    rs1data_d = regs_q[{rd_tid, rs1addr}];
    rs2data_d = regs_q[{rd_tid, rs2addr}];
    if (wr_acc && (wtid == rd_tid) && (waddr == rs1addr)) rs1data_d = wdata;
    if (wr_acc && (wtid == rd_tid) && (waddr == rs2addr)) rs2data_d = wdata;
`ifdef REGFILE_ZERO_REG_EN
    if (rs1addr == '0) rs1data_d = '0;
    if (rs2addr == '0) rs2data_d = '0;
`endif
  end

  // Storage has no reset so it maps onto block RAM; the clear FSM owns the port while busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      regs_q[{wtid, waddr}] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rs1data_q  <= '0;
      rs2data_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rs1data_q <= rs1data_d;
        rs2data_q <= rs2data_d;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rs1data  = rs1data_q;
  assign rs2data  = rs2data_q;

endmodule

// File: tb/tb_mt_regfile.sv
// Self-checking bench for mt_regfile: behavioural model checked every cycle plus directed literal checks.
// Honours REGFILE_ZERO_REG_EN the same way the design does.
module tb_mt_regfile;

  localparam int DW = 64;
  localparam int TW = 2;
  localparam int NR = 16;
  localparam int NE = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wena = 1'b0;
  logic [TW-1:0] wtid = '0;
  logic [3:0]    waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          rd_en = 1'b0;
  logic [TW-1:0] rd_tid = '0;
  logic [3:0]    rs1addr = '0;
  logic [3:0]    rs2addr = '0;
  logic          clr_req = 1'b0;
  logic [TW-1:0] clr_tid = '0;
  logic          ready, rd_valid;
  logic [DW-1:0] rs1data, rs2data;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mdl [NE];
  int            busy = NE;
  bit            mReady = 1'b0;
  bit            mValid = 1'b0;
  logic [DW-1:0] mRs1 = '0;
  logic [DW-1:0] mRs2 = '0;

  mt_regfile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ready   (ready),
    .wena    (wena),
    .wtid    (wtid),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_en   (rd_en),
    .rd_tid  (rd_tid),
    .rs1addr (rs1addr),
    .rs2addr (rs2addr),
    .rs1data (rs1data),
    .rs2data (rs2data),
    .rd_valid(rd_valid),
    .clr_req (clr_req),
    .clr_tid (clr_tid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] modelRead(int tid, int addr, bit we, int wt, int wa,
                                              logic [DW-1:0] wd);
`ifdef REGFILE_ZERO_REG_EN
    if (addr == 0) return '0;
`endif
    if (we && wt == tid && wa == addr) return wd;
    return mdl[tid*NR + addr];
  endfunction

  // Reference model: a clear zeroes its whole thread at once, since nothing can observe it mid-way.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) mdl[i] = '0;
      busy = NE;
      mValid = 1'b0;
      mRs1 = '0;
      mRs2 = '0;
    end else if (mReady) begin
      mValid = rd_en;
      if (rd_en) begin
        mRs1 = modelRead(int'(rd_tid), int'(rs1addr), wena, int'(wtid), int'(waddr), wdata);
        mRs2 = modelRead(int'(rd_tid), int'(rs2addr), wena, int'(wtid), int'(waddr), wdata);
      end
`ifdef REGFILE_ZERO_REG_EN
      if (wena && waddr != 0) mdl[int'(wtid)*NR + int'(waddr)] = wdata;
`else
      if (wena) mdl[int'(wtid)*NR + int'(waddr)] = wdata;
`endif
      if (clr_req) begin
        for (int i = 0; i < NR; i++) mdl[int'(clr_tid)*NR + i] = '0;
        busy = NR;
      end
    end else begin
      mValid = 1'b0;
      if (busy > 0) busy--;
    end
    mReady = (busy == 0) && rst_n;
    #1;
    checkOutput("model ready", {63'd0, ready}, {63'd0, mReady});
    checkOutput("model rd_valid", {63'd0, rd_valid}, {63'd0, mValid});
    checkOutput("model rs1data", rs1data, mRs1);
    checkOutput("model rs2data", rs2data, mRs2);
  end

  // Inputs change on the falling edge and are sampled by the next rising edge.
  task automatic applyStimulus(bit we, int wt, int wa, logic [DW-1:0] wd,
                               bit re, int rt, int r1, int r2, bit cr, int ct);
    @(negedge clk);
    wena    = we;
    wtid    = TW'(wt);
    waddr   = 4'(wa);
    wdata   = wd;
    rd_en   = re;
    rd_tid  = TW'(rt);
    rs1addr = 4'(r1);
    rs2addr = 4'(r2);
    clr_req = cr;
    clr_tid = TW'(ct);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic releaseAndSweep();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (63) idle();
    checkOutput("sweep ready low at 63", {63'd0, ready}, 64'd0);
    idle();
    checkOutput("sweep ready high at 64", {63'd0, ready}, 64'd1);
  endtask

  initial begin
    logic [DW-1:0] z0exp;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", {63'd0, ready}, 64'd0);
    checkOutput("reset rd_valid", {63'd0, rd_valid}, 64'd0);
    checkOutput("reset rs1data", rs1data, 64'd0);

    releaseAndSweep();
    for (int e = 0; e < NE; e++) applyStimulus(0, 0, 0, '0, 1, e / NR, e % NR, (e + 1) % NR, 0, 0);
    idle();
    checkOutput("sweep read t3 r15", rs1data, 64'd0);
    checkOutput("sweep read valid", {63'd0, rd_valid}, 64'd1);

    applyStimulus(1, 1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 1, 1, 5, 5, 0, 0);
    applyStimulus(0, 0, 0, '0, 1, 2, 5, 5, 0, 0);
    checkOutput("t1 r5 rs1", rs1data, 64'hDEAD_BEEF);
    checkOutput("t1 r5 rs2", rs2data, 64'hDEAD_BEEF);
    checkOutput("model pins t1 r5", mRs1, 64'hDEAD_BEEF);
    idle();
    checkOutput("t2 r5 reads 0", rs1data, 64'd0);

    applyStimulus(1, 3, 6, 64'h5555, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 7, 64'h1234, 1, 3, 7, 6, 0, 0);
    applyStimulus(1, 3, 7, 64'h9999, 1, 2, 7, 6, 0, 0);
    checkOutput("bypass rs1", rs1data, 64'h1234);
    checkOutput("bypass rs2 old r6", rs2data, 64'h5555);
    idle();
    checkOutput("no bypass other tid rs1", rs1data, 64'd0);
    checkOutput("no bypass other tid rs2", rs2data, 64'd0);

    for (int e = 0; e < NE; e++) applyStimulus(1, e / NR, e % NR, 64'hA5, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < NR; i++) begin
      applyStimulus(1, 0, 1, 64'hBAD, 1, 2, 3, 4, 1, 1);
      checkOutput("clear ready low", {63'd0, ready}, 64'd0);
    end
    idle();
    checkOutput("clear ready back", {63'd0, ready}, 64'd1);
    checkOutput("clear rd_valid low", {63'd0, rd_valid}, 64'd0);
    for (int i = 0; i < NR; i++) applyStimulus(0, 0, 0, '0, 1, 2, i, (i + 1) % NR, 0, 0);
    applyStimulus(0, 0, 0, '0, 1, 0, 1, 2, 0, 0);
    checkOutput("cleared t2 r15", rs1data, 64'd0);
    applyStimulus(0, 0, 0, '0, 1, 3, 9, 1, 0, 0);
    checkOutput("t0 r1 unchanged", rs1data, 64'hA5);
    idle();
    checkOutput("t3 r9 kept", rs1data, 64'hA5);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15),
                    {$urandom, $urandom}, $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    ($urandom_range(0, 39) == 0), $urandom_range(0, 3));
    idle();
    repeat (NR + 2) idle();

    applyStimulus(1, 1, 3, 64'h77, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 1, 1, 3, 3, 0, 0);
    idle();
    checkOutput("pre-reset rs1", rs1data, 64'h77);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset rd_valid", {63'd0, rd_valid}, 64'd0);
    checkOutput("async reset rs1data", rs1data, 64'd0);
    checkOutput("async reset ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) idle();
    rst_n = 1'b0;
    #1;
    checkOutput("mid-sweep reset ready", {63'd0, ready}, 64'd0);
    releaseAndSweep();

`ifdef REGFILE_ZERO_REG_EN
    z0exp = 64'd0;
`else
    z0exp = 64'hFF;
`endif
    applyStimulus(1, 0, 0, 64'hFF, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 1, 0, 0, 1, 0, 0);
    checkOutput("r0 same-cycle read", rs1data, z0exp);
    idle();
    checkOutput("r0 later read", rs1data, z0exp);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
